mem_seg: RTL and testbench

MEM_SEG -- requirements
Module: mem_seg

---
 rtl/mem_seg_pkg.sv | 24 ++
 rtl/mem_seg_fsm.sv | 76 +++++++
 rtl/mem_seg.sv | 111 +++++++++++
 tb/tb_mem_seg.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_seg_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the opcode constants, the bubble instruction word, the IDLE/BUSY
// state encoding and a small decode helper used by mem_seg.
package mem_seg_pkg;

  // Opcode field is IR[31:26]
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;
  localparam logic [5:0] OpBeqz = 6'h04;

  // Instruction word presented downstream when no instruction is valid
  localparam logic [31:0] Bubble = 32'hFFFF_FFFF;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_t;

  // True for opcodes that access data memory
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OpLw) || (op == OpSw);
  endfunction

endpackage

// File: rtl/mem_seg_fsm.sv
// Memory-access sequencer for the MEM stage.
// Tracks IDLE/BUSY, counts falling edges spent waiting on memory and owns the
// sticky error flag. All state updates on the falling edge of clk.
//
// Ports:
//   clk        stage clock (falling-edge active)
//   rst        asynchronous active-high reset
//   start      aligned LW/SW presented by EX this cycle
//   misalign   LW/SW with a non-word-aligned address presented this cycle
//   mem_ready  memory completion, only meaningful while busy
//   busy       FSM is in BUSY (request outstanding)
//   load_done  current falling edge completes the access (busy & mem_ready)
//   err        sticky error: misaligned access or latency overrun
module mem_seg_fsm
  import mem_seg_pkg::*;
#(
  parameter int unsigned MEM_LAT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic misalign,
  input  logic mem_ready,
  output logic busy,
  output logic load_done,
  output logic err
);

  localparam int unsigned CntW = (MEM_LAT_MAX < 2) ? 1 : $clog2(MEM_LAT_MAX + 1);

  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_nxt;
  logic            err_q;

  assign cnt_nxt = cnt_q + CntW'(1);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // mem_ready is deliberately ignored here
          if (misalign) begin
            err_q <= 1'b1;
          end
          if (start) begin
            state_q <= StBusy;
            cnt_q   <= '0;
          end
        end
        StBusy: begin
          // Completion wins over a simultaneous latency overrun
          if (mem_ready) begin
            state_q <= StIdle;
          end else if (cnt_nxt == CntW'(MEM_LAT_MAX)) begin
            state_q <= StIdle;
            cnt_q   <= cnt_nxt;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_nxt;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q == StBusy);
  assign load_done = busy & mem_ready;
  assign err       = err_q;

endmodule

// File: rtl/mem_seg.sv
// MEM pipeline stage: latches the EX results, decodes the opcode, drives the
// data-memory interface for LW/SW and resolves BEQZ branches.
// Stage registers update on the falling edge of clk and freeze while a memory
// access is outstanding; stall asks the upstream stages to freeze too.
//
// Ports:
//   clk, rst            falling-edge clock, async active-high reset
//   IRi, ALUi, Bi       instruction, ALU result/address/target, store data from EX
//   condi               branch condition from EX
//   IRo                 instruction to WB (bubble while busy)
//   ALUo, LMDo          latched ALU result, loaded memory data
//   PCsel, Target       branch taken and branch target
//   stall               upstream freeze request
//   ERRo                sticky error flag
//   mem_req, mem_we     memory request / write enable
//   mem_addr, mem_wdata byte address / store data
//   mem_rdata, mem_ready load data / memory done
module mem_seg
  import mem_seg_pkg::*;
#(
  parameter int unsigned MEM_LAT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IRi,
  input  logic [31:0] ALUi,
  input  logic [31:0] Bi,
  input  logic        condi,
  output logic [31:0] IRo,
  output logic [31:0] ALUo,
  output logic [31:0] LMDo,
  output logic        PCsel,
  output logic [31:0] Target,
  output logic        stall,
  output logic        ERRo,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  logic [31:0] ir_q;
  logic [31:0] alu_q;
  logic [31:0] b_q;
  logic [31:0] lmd_q;
  logic        cond_q;

  logic        in_mem;
  logic        start;
  logic        misalign;
  logic        busy;
  logic        load_done;
  logic        err;
  logic [5:0]  op_q;

  // Decode of the incoming instruction; the FSM only acts on it while idle
  assign in_mem   = is_mem_op(IRi[31:26]);
  assign start    = in_mem & (ALUi[1:0] == 2'b00);
  assign misalign = in_mem & (ALUi[1:0] != 2'b00);

  assign op_q = ir_q[31:26];

  mem_seg_fsm #(
    .MEM_LAT_MAX(MEM_LAT_MAX)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .misalign (misalign),
    .mem_ready(mem_ready),
    .busy     (busy),
    .load_done(load_done),
    .err      (err)
  );

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      ir_q   <= Bubble;
      alu_q  <= '0;
      b_q    <= '0;
      cond_q <= 1'b0;
      lmd_q  <= '0;
    end else begin
      if (!busy) begin
        ir_q   <= IRi;
        alu_q  <= ALUi;
        b_q    <= Bi;
        cond_q <= condi;
      end
      // A timed-out access never asserts load_done, so LMD is left untouched
      if (load_done && (op_q == OpLw)) begin
        lmd_q <= mem_rdata;
      end
    end
  end

  assign IRo       = busy ? Bubble : ir_q;
  assign ALUo      = alu_q;
  assign Target    = alu_q;
  assign LMDo      = lmd_q;
  assign PCsel     = !busy && (op_q == OpBeqz) && cond_q;
  assign stall     = busy;
  assign ERRo      = err;
  assign mem_req   = busy;
  assign mem_we    = busy && (op_q == OpSw);
  assign mem_addr  = alu_q;
  assign mem_wdata = b_q;

endmodule

// File: tb/tb_mem_seg.sv
module tb_mem_seg;
  import mem_seg_pkg::*;

  localparam int unsigned LatMax = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IRi, ALUi, Bi;
  logic        condi;
  logic [31:0] IRo, ALUo, LMDo, Target;
  logic        PCsel, stall, ERRo;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  mem_seg #(
    .MEM_LAT_MAX(LatMax)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .IRi      (IRi),
    .ALUi     (ALUi),
    .Bi       (Bi),
    .condi    (condi),
    .IRo      (IRo),
    .ALUo     (ALUo),
    .LMDo     (LMDo),
    .PCsel    (PCsel),
    .Target   (Target),
    .stall    (stall),
    .ERRo     (ERRo),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference state: what the stage must show for LMD and the error flag
  logic [31:0] exp_lmd;
  logic        exp_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Active edge is the falling edge; look at outputs 1 time unit later
  task automatic edge_step();
    @(negedge clk);
    #1;
  endtask

  // One instruction through the stage. lat = falling edges after the request
  // edge at which mem_ready is raised (values above LatMax mean never).
  task automatic do_txn(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] b,
                        input logic cond, input int unsigned lat, input logic [31:0] rdata);
    logic [31:0] ir;
    logic        is_mem;
    logic        aligned;
    ir      = {op, 26'($urandom)};
    is_mem  = (op == OpLw) || (op == OpSw);
    aligned = (alu[1:0] == 2'b00);
    IRi       = ir;
    ALUi      = alu;
    Bi        = b;
    condi     = cond;
    mem_ready = 1'($urandom_range(0, 1));  // ignored while idle
    mem_rdata = $urandom;
    edge_step();
    if (!is_mem || !aligned) begin
      if (is_mem) exp_err = 1'b1;
      check_eq("ir_pass", IRo, ir);
      check_eq("alu_out", ALUo, alu);
      check_eq("target", Target, alu);
      check_eq("pcsel", 32'(PCsel), 32'((op == OpBeqz) && cond));
      check_eq("no_req", 32'(mem_req), 32'd0);
      check_eq("no_stall", 32'(stall), 32'd0);
      check_eq("err_idle", 32'(ERRo), 32'(exp_err));
      check_eq("lmd_hold", LMDo, exp_lmd);
    end else begin
      // Inputs change while busy; the stage must ignore them
      IRi   = $urandom;
      ALUi  = $urandom;
      Bi    = $urandom;
      condi = 1'($urandom_range(0, 1));
      for (int k = 1; k <= int'(LatMax); k++) begin
        check_eq("busy_stall", 32'(stall), 32'd1);
        check_eq("busy_req", 32'(mem_req), 32'd1);
        check_eq("busy_we", 32'(mem_we), 32'(op == OpSw));
        check_eq("busy_addr", mem_addr, alu);
        check_eq("busy_wdata", mem_wdata, b);
        check_eq("busy_ir", IRo, Bubble);
        check_eq("busy_pcsel", 32'(PCsel), 32'd0);
        mem_ready = (k == int'(lat));
        mem_rdata = (k == int'(lat)) ? rdata : $urandom;
        edge_step();
        if (k == int'(lat)) begin
          if (op == OpLw) exp_lmd = rdata;
          break;
        end
        if (k == int'(LatMax)) exp_err = 1'b1;
      end
      mem_ready = 1'b0;
      check_eq("done_stall", 32'(stall), 32'd0);
      check_eq("done_req", 32'(mem_req), 32'd0);
      check_eq("done_ir", IRo, ir);
      check_eq("done_alu", ALUo, alu);
      check_eq("done_lmd", LMDo, exp_lmd);
      check_eq("done_err", 32'(ERRo), 32'(exp_err));
    end
  endtask

  task automatic rand_txn(input bit allow_err);
    logic [5:0]  op;
    logic [31:0] alu;
    int unsigned sel;
    int unsigned lat;
    sel = $urandom_range(0, 5);
    case (sel)
      0, 1:    op = OpLw;
      2:       op = OpSw;
      3:       op = OpBeqz;
      4:       op = 6'h3F;
      default: op = 6'h08;
    endcase
    alu = $urandom;
    if (!allow_err || ($urandom_range(0, 3) != 0)) alu[1:0] = 2'b00;
    lat = allow_err ? $urandom_range(1, LatMax + 3) : $urandom_range(1, LatMax);
    do_txn(op, alu, $urandom, 1'($urandom_range(0, 1)), lat, $urandom);
  endtask

  initial begin
    rst       = 1'b1;
    IRi       = 32'd0;
    ALUi      = 32'd0;
    Bi        = 32'd0;
    condi     = 1'b0;
    mem_rdata = 32'd0;
    mem_ready = 1'b0;
    exp_lmd   = 32'd0;
    exp_err   = 1'b0;
    #3;
    check_eq("rst_ir", IRo, Bubble);
    check_eq("rst_alu", ALUo, 32'd0);
    check_eq("rst_lmd", LMDo, 32'd0);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_pcsel", 32'(PCsel), 32'd0);
    check_eq("rst_err", 32'(ERRo), 32'd0);
    edge_step();
    rst = 1'b0;

    // Directed: LW with 2-cycle latency, SW with 1-cycle latency, BEQZ both ways
    do_txn(OpLw, 32'h100, 32'h0, 1'b0, 2, 32'hDEAD_BEEF);
    check_eq("lw_lmd", LMDo, 32'hDEAD_BEEF);
    do_txn(OpSw, 32'h40, 32'h1234_5678, 1'b0, 1, 32'hAAAA_5555);
    check_eq("sw_lmd", LMDo, 32'hDEAD_BEEF);
    do_txn(OpBeqz, 32'h2000, 32'h0, 1'b1, 1, 32'h0);
    do_txn(OpBeqz, 32'h2000, 32'h0, 1'b0, 1, 32'h0);
    do_txn(OpLw, 32'h200, 32'h0, 1'b0, LatMax, 32'h0BAD_F00D);

    for (int i = 0; i < 40; i++) rand_txn(1'b0);

    // Misaligned LW: no request, sticky error
    do_txn(OpLw, 32'h102, 32'h0, 1'b0, 1, 32'h0);
    check_eq("mis_err", 32'(ERRo), 32'd1);
    do_txn(6'h08, 32'h0, 32'h0, 1'b0, 1, 32'h0);
    check_eq("mis_sticky", 32'(ERRo), 32'd1);

    // LW that never completes: abandoned after LatMax edges
    do_txn(OpLw, 32'h300, 32'h0, 1'b0, LatMax + 5, 32'h0);

    for (int i = 0; i < 30; i++) rand_txn(1'b1);

    // Reset pulsed in the middle of an access
    IRi       = {OpSw, 26'd0};
    ALUi      = 32'h400;
    Bi        = 32'h5555_AAAA;
    mem_ready = 1'b0;
    edge_step();
    edge_step();
    check_eq("pre_rst_req", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_req", 32'(mem_req), 32'd0);
    check_eq("mid_rst_we", 32'(mem_we), 32'd0);
    check_eq("mid_rst_stall", 32'(stall), 32'd0);
    check_eq("mid_rst_ir", IRo, Bubble);
    check_eq("mid_rst_alu", ALUo, 32'd0);
    check_eq("mid_rst_wdata", mem_wdata, 32'd0);
    check_eq("mid_rst_lmd", LMDo, 32'd0);
    check_eq("mid_rst_err", 32'(ERRo), 32'd0);
    edge_step();
    rst     = 1'b0;
    exp_lmd = 32'd0;
    exp_err = 1'b0;
    do_txn(OpLw, 32'h500, 32'h0, 1'b0, 3, 32'hCAFE_0001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
